// File: rtl/spike_input_queue.sv
// Spike event queue: buffers valid/ready spike indices and presents them one at a time
// to network_processor through a registered occurred/index/ack handshake.
module spike_input_queue #(
   parameter int unsigned IDX_WIDTH = 14,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [IDX_WIDTH-1:0] in_index,
   output logic                 in_ready,
   output logic                 input_occurred,
   output logic [IDX_WIDTH-1:0] input_index,
   input  logic                 input_ack,
   output logic [CNT_WIDTH-1:0] count
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

   state_e               state_q;
   logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 occurred_q;
   logic [IDX_WIDTH-1:0] index_q;
   logic [IDX_WIDTH-1:0] mem [DEPTH];

   logic full, push, pop;

   assign full     = (count_q == CNT_WIDTH'(DEPTH));
   // Held low during reset so the source sees no room until the queue is live.
   assign in_ready = reset && !full && !flush;
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == StPresent) && input_ack && !flush;

   always_comb begin
      count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= in_index;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         occurred_q <= 1'b0;
         index_q    <= '0;
      end else if (flush) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         occurred_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
         count_q <= count_d;
         unique case (state_q)
            StIdle: begin
               if (count_q != '0) begin
                  state_q    <= StPresent;
                  occurred_q <= 1'b1;
                  index_q    <= mem[rd_ptr_q];
               end
            end
            StPresent: begin
               if (input_ack) begin
                  state_q    <= StGap;
                  occurred_q <= 1'b0;
               end
            end
            StGap: begin
               if (count_d != '0) begin
                  state_q    <= StPresent;
                  occurred_q <= 1'b1;
                  // An empty queue refilled this edge: the RAM write is not visible yet.
                  index_q    <= (count_q == '0) ? in_index : mem[rd_ptr_q];
               end else begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign input_occurred = occurred_q;
   assign input_index    = index_q;
   assign count          = count_q;

endmodule

// File: tb/tb_spike_input_queue.sv
// Directed self-checking bench for spike_input_queue (DEPTH=8, IDX_WIDTH=14).
module tb_spike_input_queue;

   localparam int unsigned IDX_WIDTH = 14;
   localparam int unsigned DEPTH     = 8;
   localparam int unsigned CNT_WIDTH = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 flush;
   logic                 in_valid;
   logic [IDX_WIDTH-1:0] in_index;
   logic                 in_ready;
   logic                 input_occurred;
   logic [IDX_WIDTH-1:0] input_index;
   logic                 input_ack;
   logic [CNT_WIDTH-1:0] count;

   int checks = 0;
   int errors = 0;
   int k;

   spike_input_queue #(
      .IDX_WIDTH (IDX_WIDTH),
      .DEPTH     (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_index       (in_index),
      .in_ready       (in_ready),
      .input_occurred (input_occurred),
      .input_index    (input_index),
      .input_ack      (input_ack),
      .count          (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected per-edge traces for the burst (test 2) and held-ack (test 4) sequences.
   logic [13:0] b_val [10] = '{14'd3, 14'd7, 14'd11, 14'd13, 0, 0, 0, 0, 0, 0};
   logic        b_occ [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
   logic [13:0] b_idx [10] = '{0, 14'd3, 0, 14'd7, 0, 14'd11, 0, 14'd13, 0, 0};
   logic [3:0]  b_cnt [10] = '{1, 2, 2, 3, 2, 2, 1, 1, 0, 0};
   logic        h_occ [9]  = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
   logic [13:0] h_idx [9]  = '{0, 14'd40, 0, 14'd41, 0, 14'd42, 0, 0, 0};
   logic [3:0]  h_cnt [9]  = '{1, 2, 2, 2, 1, 1, 0, 0, 0};

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_index = '0; input_ack = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_occurred", 32'(input_occurred), 0);
      check("rst_count", 32'(count), 0);
      check("rst_index", 32'(input_index), 0);
      reset = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 1);

      // Test 1: single event latency and ack.
      in_valid = 1'b1; in_index = 14'd5;
      tick();
      in_valid = 1'b0;
      check("t1_count_push", 32'(count), 1);
      check("t1_occ_early", 32'(input_occurred), 0);
      tick();
      check("t1_occ", 32'(input_occurred), 1);
      check("t1_index", 32'(input_index), 5);
      input_ack = 1'b1;
      tick();
      input_ack = 1'b0;
      check("t1_occ_ack", 32'(input_occurred), 0);
      check("t1_count_ack", 32'(count), 0);
      tick();
      check("t1_occ_idle", 32'(input_occurred), 0);

      // Test 2: burst, controller acks on first PRESENT cycle.
      for (int i = 0; i < 10; i++) begin
         in_valid  = (i < 4);
         in_index  = b_val[i];
         input_ack = input_occurred;
         tick();
         check("t2_occ", 32'(input_occurred), 32'(b_occ[i]));
         if (b_occ[i]) check("t2_index", 32'(input_index), 32'(b_idx[i]));
         check("t2_count", 32'(count), 32'(b_cnt[i]));
      end
      in_valid = 1'b0; input_ack = 1'b0;

      // Test 3: fill to full, held 9th event, ack+push while full.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_index = 14'(20 + i);
         tick();
      end
      check("t3_count_full", 32'(count), 8);
      check("t3_ready_full", 32'(in_ready), 0);
      check("t3_index_head", 32'(input_index), 20);
      in_index = 14'd99;
      tick();
      tick();
      check("t3_count_held", 32'(count), 8);
      check("t3_index_held", 32'(input_index), 20);
      input_ack = 1'b1;
      tick();
      input_ack = 1'b0; in_valid = 1'b0;
      check("t3_count_ackpush", 32'(count), 7);
      check("t3_occ_ackpush", 32'(input_occurred), 0);
      k = 0;
      for (int i = 0; i < 16; i++) begin
         input_ack = input_occurred;
         tick();
         if (input_occurred) begin
            check("t3_drain_index", 32'(input_index), 32'(21 + k));
            k++;
         end
      end
      input_ack = 1'b0;
      check("t3_drain_num", 32'(k), 7);
      check("t3_count_drained", 32'(count), 0);

      // Test 4: ack ignored in IDLE, then held high across 3 queued events.
      input_ack = 1'b1;
      tick();
      check("t4_idle_ack_count", 32'(count), 0);
      check("t4_idle_ack_occ", 32'(input_occurred), 0);
      for (int i = 0; i < 9; i++) begin
         in_valid = (i < 3);
         in_index = 14'(40 + i);
         tick();
         check("t4_occ", 32'(input_occurred), 32'(h_occ[i]));
         if (h_occ[i]) check("t4_index", 32'(input_index), 32'(h_idx[i]));
         check("t4_count", 32'(count), 32'(h_cnt[i]));
      end
      in_valid = 1'b0; input_ack = 1'b0;

      // Test 5: flush while PRESENT with ack and push asserted.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_index = 14'(50 + i);
         tick();
      end
      in_valid = 1'b0;
      check("t5_count_pre", 32'(count), 4);
      check("t5_occ_pre", 32'(input_occurred), 1);
      flush = 1'b1; input_ack = 1'b1; in_valid = 1'b1; in_index = 14'd77;
      #1;
      check("t5_ready_flush", 32'(in_ready), 0);
      tick();
      flush = 1'b0; input_ack = 1'b0; in_valid = 1'b0;
      check("t5_count_flush", 32'(count), 0);
      check("t5_occ_flush", 32'(input_occurred), 0);
      tick();
      check("t5_occ_after", 32'(input_occurred), 0);
      in_valid = 1'b1; in_index = 14'd9;
      tick();
      in_valid = 1'b0;
      tick();
      check("t5_occ_new", 32'(input_occurred), 1);
      check("t5_index_new", 32'(input_index), 9);
      input_ack = 1'b1;
      tick();
      input_ack = 1'b0;
      check("t5_count_end", 32'(count), 0);
      tick();

      // Test 6: async reset mid-handshake.
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_index = 14'(60 + i);
         tick();
      end
      in_valid = 1'b0;
      check("t6_occ_pre", 32'(input_occurred), 1);
      check("t6_count_pre", 32'(count), 2);
      reset = 1'b0;
      #1;
      check("t6_occ_async", 32'(input_occurred), 0);
      check("t6_count_async", 32'(count), 0);
      check("t6_ready_async", 32'(in_ready), 0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("t6_count_rel", 32'(count), 0);
      check("t6_ready_rel", 32'(in_ready), 1);
      in_valid = 1'b1; in_index = 14'd70;
      tick();
      in_valid = 1'b0;
      tick();
      check("t6_occ_new", 32'(input_occurred), 1);
      check("t6_index_new", 32'(input_index), 70);
      input_ack = 1'b1;
      tick();
      input_ack = 1'b0;
      check("t6_occ_ack", 32'(input_occurred), 0);
      check("t6_count_end", 32'(count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
